execute_mc: RTL and testbench

Parametrised, multi-cycle execute stage for the pipelined CPU. It sits between decode and memory and resolves operand forwarding from the EX/MEM and WB stages, single-cycle ALU ops, branches and register jumps. It also adds an iterative multiply/divide unit that stalls the front of the pipeline while it runs. Outputs are registered into the EX/MEM boundary; branch resolution is combinational to fetch.

---
 rtl/exec_pkg.sv | 55 +++++
 rtl/muldiv_iter.sv | 107 ++++++++++
 rtl/execute_mc.sv | 208 ++++++++++++++++++++
 tb/tb_execute_mc.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared constants and types for the multi-cycle execute stage.
// Opcodes, ALU ops, branch codes, flag indices and the mul/div FSM.
package exec_pkg;

  localparam logic [2:0] OPC_ALU = 3'b000;
  localparam logic [2:0] OPC_RI1 = 3'b001;
  localparam logic [2:0] OPC_LI  = 3'b011;
  localparam logic [2:0] OPC_RI4 = 3'b100;
  localparam logic [2:0] OPC_RI5 = 3'b101;
  localparam logic [2:0] OPC_BR  = 3'b110;
  localparam logic [2:0] OPC_JR  = 3'b111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SHL  = 4'd5;
  localparam logic [3:0] ALU_SHR  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_MULL = 4'd8;
  localparam logic [3:0] ALU_MULH = 4'd9;
  localparam logic [3:0] ALU_UDIV = 4'd10;
  localparam logic [3:0] ALU_UREM = 4'd11;

  localparam logic [5:0] BR_Z   = 6'd0;
  localparam logic [5:0] BR_P   = 6'd1;
  localparam logic [5:0] BR_N   = 6'd2;
  localparam logic [5:0] BR_C   = 6'd3;
  localparam logic [5:0] BR_O   = 6'd4;
  localparam logic [5:0] BR_NE  = 6'd5;
  localparam logic [5:0] BR_JMP = 6'd6;
  localparam logic [5:0] BR_NC  = 6'd7;
  localparam logic [5:0] BR_G   = 6'd8;
  localparam logic [5:0] BR_GE  = 6'd9;
  localparam logic [5:0] BR_L   = 6'd10;
  localparam logic [5:0] BR_LE  = 6'd11;
  localparam logic [5:0] BR_A   = 6'd12;
  localparam logic [5:0] BR_AE  = 6'd13;
  localparam logic [5:0] BR_B   = 6'd14;
  localparam logic [5:0] BR_BE  = 6'd15;
  localparam logic [5:0] BR_NO  = 6'd16;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide.
// One bit per cycle; kind 00 mul-lo, 01 mul-hi, 10 div, 11 rem.
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [1:0]       kind_i,
  input  logic [WIDTH-1:0] lhs_i,
  input  logic [WIDTH-1:0] rhs_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [1:0]       kind_q, kind_d;

  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   rsh;
  logic [WIDTH-1:0] rdif;
  logic             qbit;

  // One shift-add step and one restoring-divide step.
  always_comb begin
    msum = {1'b0, acc_q}
         + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rsh  = {acc_q, lo_q[WIDTH-1]};
    rdif = rsh[WIDTH-1:0] - opnd_q;
    qbit = (rsh >= {1'b0, opnd_q});
  end

  // Next-state logic; abort always wins back to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    kind_d  = kind_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = CW'(WIDTH - 1);
          acc_d   = '0;
          kind_d  = kind_i;
          lo_d    = kind_i[1] ? lhs_i : rhs_i;
          opnd_d  = kind_i[1] ? rhs_i : lhs_i;
        end
      end
      MD_BUSY: begin
        if (kind_q[1]) begin
          acc_d = qbit ? rdif : rsh[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], qbit};
        end else begin
          {acc_d, lo_d} = {msum, lo_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (abort_i) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      kind_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      kind_q  <= kind_d;
    end
  end

  assign busy_o   = (state_q == MD_BUSY);
  assign done_o   = (state_q == MD_DONE);
  assign result_o = kind_q[0] ? acc_q : lo_q;

endmodule

// File: rtl/execute_mc.sv
// Execute stage: forwarding, ALU, branch resolve, iterative mul/div.
// Results are registered into EX/MEM; redirect is combinational.
module execute_mc
  import exec_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bubble_in,
  input  logic                flush_in,
  input  logic [2:0]          opcode,
  input  logic [3:0]          alu_op,
  input  logic [5:0]          branch_code,
  input  logic [REG_BITS-1:0] s_1,
  input  logic [REG_BITS-1:0] s_2,
  input  logic [REG_BITS-1:0] tgt,
  input  logic [WIDTH-1:0]    imm,
  input  logic [WIDTH-1:0]    reg_out_1,
  input  logic [WIDTH-1:0]    reg_out_2,
  input  logic [REG_BITS-1:0] wb_tgt,
  input  logic [WIDTH-1:0]    wb_result_out,
  input  logic [WIDTH-1:0]    pc_in,
  output logic [WIDTH-1:0]    result,
  output logic [WIDTH-1:0]    store_data,
  output logic [REG_BITS-1:0] tgt_out,
  output logic [2:0]          opcode_out,
  output logic                bubble_out,
  output logic                stall,
  output logic                branch,
  output logic [WIDTH-1:0]    branch_tgt
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0]    result_q, result_d;
  logic [WIDTH-1:0]    store_q, store_d;
  logic [REG_BITS-1:0] tgt_q, tgt_d;
  logic [2:0]          opc_q, opc_d;
  logic                bub_q, bub_d;

  logic [WIDTH-1:0] op1, op2, lhs, rhs;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   sum_w, dif_w;
  logic [SHW-1:0]   shamt;
  logic             c_f, v_f;
  logic [3:0]       flags;
  logic             cond, taken;
  logic             md_op, md_valid;
  logic             md_busy, md_done;
  logic [WIDTH-1:0] md_res;

  // Operand forwarding: EX/MEM first, then WB, then regfile.
  always_comb begin
    op1 = reg_out_1;
    if (s_1 != '0 && !bub_q && tgt_q == s_1) begin
      op1 = result_q;
    end else if (s_1 != '0 && wb_tgt == s_1) begin
      op1 = wb_result_out;
    end
    op2 = reg_out_2;
    if (s_2 != '0 && !bub_q && tgt_q == s_2) begin
      op2 = result_q;
    end else if (s_2 != '0 && wb_tgt == s_2) begin
      op2 = wb_result_out;
    end
  end

  assign lhs = (opcode == OPC_LI) ? imm : op1;
  assign rhs = (opcode == OPC_RI1 ||
                opcode == OPC_RI4 ||
                opcode == OPC_RI5) ? imm : op2;

  assign sum_w = {1'b0, lhs} + {1'b0, rhs};
  assign dif_w = {1'b0, lhs} - {1'b0, rhs};
  assign shamt = rhs[SHW-1:0];

  // Single-cycle ALU; C means no-borrow on subtract.
  always_comb begin
    alu_res = '0;
    c_f     = 1'b0;
    v_f     = 1'b0;
    unique case (alu_op)
      ALU_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        c_f     = sum_w[WIDTH];
        v_f     = (lhs[WIDTH-1] == rhs[WIDTH-1])
               && (alu_res[WIDTH-1] != lhs[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = dif_w[WIDTH-1:0];
        c_f     = !dif_w[WIDTH];
        v_f     = (lhs[WIDTH-1] != rhs[WIDTH-1])
               && (alu_res[WIDTH-1] != lhs[WIDTH-1]);
      end
      ALU_AND: alu_res = lhs & rhs;
      ALU_OR:  alu_res = lhs | rhs;
      ALU_XOR: alu_res = lhs ^ rhs;
      ALU_SHL: alu_res = lhs << shamt;
      ALU_SHR: alu_res = lhs >> shamt;
      ALU_SRA: alu_res = $unsigned($signed(lhs) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  assign flags[FLG_C] = c_f;
  assign flags[FLG_Z] = (alu_res == '0);
  assign flags[FLG_N] = alu_res[WIDTH-1];
  assign flags[FLG_V] = v_f;

  // Branch condition decode from the current flags.
  always_comb begin
    cond = 1'b0;
    unique case (branch_code)
      BR_Z:    cond = flags[FLG_Z];
      BR_P:    cond = !flags[FLG_N] && !flags[FLG_Z];
      BR_N:    cond = flags[FLG_N];
      BR_C:    cond = flags[FLG_C];
      BR_O:    cond = flags[FLG_V];
      BR_NE:   cond = !flags[FLG_Z];
      BR_JMP:  cond = 1'b1;
      BR_NC:   cond = !flags[FLG_C];
      BR_G:    cond = !flags[FLG_Z]
                   && (flags[FLG_N] == flags[FLG_V]);
      BR_GE:   cond = (flags[FLG_N] == flags[FLG_V]);
      BR_L:    cond = (flags[FLG_N] != flags[FLG_V]);
      BR_LE:   cond = flags[FLG_Z]
                   || (flags[FLG_N] != flags[FLG_V]);
      BR_A:    cond = flags[FLG_C] && !flags[FLG_Z];
      BR_AE:   cond = flags[FLG_C];
      BR_B:    cond = !flags[FLG_C];
      BR_BE:   cond = !flags[FLG_C] || flags[FLG_Z];
      BR_NO:   cond = !flags[FLG_V];
      default: cond = 1'b0;
    endcase
  end

  assign taken = (opcode == OPC_BR) ? cond
                                    : (opcode == OPC_JR);

  assign md_op    = (alu_op[3:2] == 2'b10);
  assign md_valid = md_op && !bubble_in && !flush_in;

  muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_valid),
    .abort_i  (flush_in),
    .kind_i   (alu_op[1:0]),
    .lhs_i    (lhs),
    .rhs_i    (rhs),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_res)
  );

  assign stall = !flush_in
              && ((md_valid && !md_busy && !md_done)
                  || md_busy);

  assign branch = !bubble_in && !flush_in
               && !stall && taken;

  assign branch_tgt = (opcode == OPC_JR) ? alu_res :
                      cond ? pc_in + imm + WIDTH'(1)
                           : pc_in + WIDTH'(1);

  // EX/MEM next values; empty, flushed or stalled slots are bubbles.
  always_comb begin
    result_d = result_q;
    store_d  = store_q;
    opc_d    = opc_q;
    tgt_d    = '0;
    bub_d    = 1'b1;
    if (!bubble_in && !flush_in && !stall) begin
      result_d = md_op ? md_res : alu_res;
      store_d  = op2;
      opc_d    = opcode;
      tgt_d    = tgt;
      bub_d    = 1'b0;
    end
  end

  // EX/MEM pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      store_q  <= '0;
      tgt_q    <= '0;
      opc_q    <= '0;
      bub_q    <= 1'b1;
    end else begin
      result_q <= result_d;
      store_q  <= store_d;
      tgt_q    <= tgt_d;
      opc_q    <= opc_d;
      bub_q    <= bub_d;
    end
  end

  assign result     = result_q;
  assign store_data = store_q;
  assign tgt_out    = tgt_q;
  assign opcode_out = opc_q;
  assign bubble_out = bub_q;

endmodule

// File: tb/tb_execute_mc.sv
// Directed bench for execute_mc at WIDTH=16, REG_BITS=3.
// Hand-computed vectors for forwarding, ALU, mul/div and branches.
module tb_execute_mc;

  localparam int W  = 16;
  localparam int RB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          bubble_in, flush_in;
  logic [2:0]    opcode;
  logic [3:0]    alu_op;
  logic [5:0]    branch_code;
  logic [RB-1:0] s_1, s_2, tgt, wb_tgt;
  logic [W-1:0]  imm, reg_out_1, reg_out_2;
  logic [W-1:0]  wb_result_out, pc_in;
  logic [W-1:0]  result, store_data, branch_tgt;
  logic [RB-1:0] tgt_out;
  logic [2:0]    opcode_out;
  logic          bubble_out, stall, branch;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  execute_mc #(.WIDTH(W), .REG_BITS(RB)) dut (
    .clk           (clk),
    .rst           (rst),
    .bubble_in     (bubble_in),
    .flush_in      (flush_in),
    .opcode        (opcode),
    .alu_op        (alu_op),
    .branch_code   (branch_code),
    .s_1           (s_1),
    .s_2           (s_2),
    .tgt           (tgt),
    .imm           (imm),
    .reg_out_1     (reg_out_1),
    .reg_out_2     (reg_out_2),
    .wb_tgt        (wb_tgt),
    .wb_result_out (wb_result_out),
    .pc_in         (pc_in),
    .result        (result),
    .store_data    (store_data),
    .tgt_out       (tgt_out),
    .opcode_out    (opcode_out),
    .bubble_out    (bubble_out),
    .stall         (stall),
    .branch        (branch),
    .branch_tgt    (branch_tgt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bubble_in     = 1'b1;
    flush_in      = 1'b0;
    opcode        = '0;
    alu_op        = '0;
    branch_code   = '0;
    s_1           = '0;
    s_2           = '0;
    tgt           = '0;
    imm           = '0;
    reg_out_1     = '0;
    reg_out_2     = '0;
    wb_tgt        = '0;
    wb_result_out = '0;
    pc_in         = '0;
  endtask

  task automatic op(input logic [2:0] opc,
                    input logic [3:0] alu,
                    input logic [5:0] bc,
                    input logic [RB-1:0] a_s,
                    input logic [RB-1:0] b_s,
                    input logic [RB-1:0] t,
                    input logic [W-1:0] r1,
                    input logic [W-1:0] r2,
                    input logic [W-1:0] im);
    bubble_in   = 1'b0;
    opcode      = opc;
    alu_op      = alu;
    branch_code = bc;
    s_1         = a_s;
    s_2         = b_s;
    tgt         = t;
    reg_out_1   = r1;
    reg_out_2   = r2;
    imm         = im;
  endtask

  task automatic alu1(input string tag,
                      input logic [3:0] alu,
                      input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic [W-1:0] exp);
    op(3'b001, alu, 6'd0, 3'd6, 3'd0, 3'd7, a, 16'h0, b);
    tick();
    check(tag, 32'(result), 32'(exp));
  endtask

  task automatic md_run(input string tag,
                        input logic [3:0] alu,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] exp);
    int st;
    int lat;
    bit done;
    idle_in();
    tick();
    op(3'b000, alu, 6'd0, 3'd4, 3'd5, 3'd6, a, b, 16'h0);
    st   = 0;
    lat  = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (stall) st++;
      tick();
      lat++;
      if (!bubble_out) done = 1'b1;
    end
    check({tag, " latency"}, 32'(lat), 32'd18);
    check({tag, " stall"}, 32'(st), 32'd17);
    check(tag, 32'(result), 32'(exp));
    check({tag, " tgt"}, 32'(tgt_out), 32'd6);
    idle_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst bubble", 32'(bubble_out), 32'd1);
    check("rst tgt", 32'(tgt_out), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst store", 32'(store_data), 32'd0);
    check("rst opc", 32'(opcode_out), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    check("rst branch", 32'(branch), 32'd0);

    // add r1 = 5, then sub r2,r1,r1 via EX/MEM
    op(3'b001, 4'd0, 6'd0, 3'd0, 3'd0, 3'd1,
       16'h0, 16'h0, 16'd5);
    tick();
    check("add r1", 32'(result), 32'd5);
    check("add tgt", 32'(tgt_out), 32'd1);
    check("add bub", 32'(bubble_out), 32'd0);
    check("add opc", 32'(opcode_out), 32'd1);
    op(3'b000, 4'd1, 6'd0, 3'd1, 3'd1, 3'd2,
       16'h1234, 16'h0034, 16'h0);
    tick();
    check("exmem sub", 32'(result), 32'd0);
    check("exmem st", 32'(store_data), 32'd5);

    // same pair with a bubble between: WB path
    op(3'b001, 4'd0, 6'd0, 3'd0, 3'd0, 3'd1,
       16'h0, 16'h0, 16'd5);
    tick();
    idle_in();
    wb_tgt = 3'd1;
    wb_result_out = 16'd5;
    tick();
    op(3'b000, 4'd1, 6'd0, 3'd1, 3'd1, 3'd2,
       16'h1234, 16'h0034, 16'h0);
    tick();
    check("wb sub", 32'(result), 32'd0);
    check("wb st", 32'(store_data), 32'd5);

    // EX/MEM beats WB: 5 - 2
    wb_tgt = 3'd0;
    op(3'b001, 4'd0, 6'd0, 3'd0, 3'd0, 3'd1,
       16'h0, 16'h0, 16'd5);
    tick();
    op(3'b000, 4'd1, 6'd0, 3'd1, 3'd3, 3'd2,
       16'h1234, 16'h0002, 16'h0);
    wb_tgt = 3'd1;
    wb_result_out = 16'd7;
    tick();
    check("fwd prio", 32'(result), 32'd3);

    // r0 is never forwarded
    wb_tgt = 3'd0;
    op(3'b001, 4'd0, 6'd0, 3'd0, 3'd0, 3'd0,
       16'h0, 16'h0, 16'd9);
    tick();
    op(3'b000, 4'd0, 6'd0, 3'd0, 3'd0, 3'd3,
       16'h1, 16'h2, 16'h0);
    wb_tgt = 3'd0;
    wb_result_out = 16'h77;
    tick();
    check("r0 nofwd", 32'(result), 32'd3);
    wb_result_out = 16'h0;

    alu1("and", 4'd2, 16'hF0F0, 16'h0FF0, 16'h00F0);
    alu1("or", 4'd3, 16'hF000, 16'h000F, 16'hF00F);
    alu1("xor", 4'd4, 16'hAAAA, 16'hFFFF, 16'h5555);
    alu1("shl15", 4'd5, 16'h0001, 16'd15, 16'h8000);
    alu1("shl wrap", 4'd5, 16'h0001, 16'h0011, 16'h0002);
    alu1("shr", 4'd6, 16'h8000, 16'd4, 16'h0800);
    alu1("sra", 4'd7, 16'h8000, 16'd3, 16'hF000);
    alu1("op12", 4'd12, 16'd5, 16'd5, 16'h0000);
    alu1("add wrap", 4'd0, 16'hFFFF, 16'd1, 16'h0000);

    md_run("mulh", 4'd9, 16'hFFFF, 16'hFFFF, 16'hFFFE);
    md_run("mull", 4'd8, 16'h1234, 16'h0003, 16'h369C);
    md_run("udiv", 4'd10, 16'd100, 16'd7, 16'd14);
    md_run("urem", 4'd11, 16'd100, 16'd7, 16'd2);
    md_run("udiv0", 4'd10, 16'd9, 16'd0, 16'hFFFF);
    md_run("urem0", 4'd11, 16'd9, 16'd0, 16'd9);

    // flush five cycles into a divide
    tick();
    op(3'b000, 4'd10, 6'd0, 3'd4, 3'd5, 3'd6,
       16'd100, 16'd7, 16'h0);
    for (int i = 0; i < 5; i++) tick();
    check("pre flush stall", 32'(stall), 32'd1);
    flush_in = 1'b1;
    #1;
    check("flush stall", 32'(stall), 32'd0);
    tick();
    check("flush bub", 32'(bubble_out), 32'd1);
    check("flush tgt", 32'(tgt_out), 32'd0);
    idle_in();
    #1;
    check("flush idle", 32'(stall), 32'd0);
    md_run("div post flush", 4'd10, 16'd100,
           16'd7, 16'd14);

    // reset in the middle of a divide
    op(3'b000, 4'd10, 6'd0, 3'd4, 3'd5, 3'd6,
       16'd100, 16'd7, 16'h0);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    check("mrst result", 32'(result), 32'd0);
    check("mrst bub", 32'(bubble_out), 32'd1);
    check("mrst opc", 32'(opcode_out), 32'd0);
    idle_in();
    rst = 1'b0;
    #1;
    check("mrst stall", 32'(stall), 32'd0);

    // beq taken, bubbled, not taken
    op(3'b110, 4'd1, 6'd0, 3'd4, 3'd5, 3'd0,
       16'd3, 16'd3, 16'd4);
    pc_in = 16'h0010;
    #1;
    check("beq br", 32'(branch), 32'd1);
    check("beq tgt", 32'(branch_tgt), 32'h15);
    bubble_in = 1'b1;
    #1;
    check("beq bubble", 32'(branch), 32'd0);
    bubble_in = 1'b0;
    reg_out_2 = 16'd2;
    #1;
    check("beq nt", 32'(branch), 32'd0);
    check("beq nt tgt", 32'(branch_tgt), 32'h11);

    // register jump to 0x40 + 2
    op(3'b111, 4'd0, 6'd0, 3'd4, 3'd5, 3'd0,
       16'h0040, 16'h0002, 16'h0);
    #1;
    check("jr br", 32'(branch), 32'd1);
    check("jr tgt", 32'(branch_tgt), 32'h42);

    // overflow, signed less, unsigned below
    op(3'b110, 4'd0, 6'd4, 3'd4, 3'd5, 3'd0,
       16'h7FFF, 16'h0001, 16'h0);
    #1;
    check("bo", 32'(branch), 32'd1);
    op(3'b110, 4'd1, 6'd10, 3'd4, 3'd5, 3'd0,
       16'hFFFF, 16'h0001, 16'h0);
    #1;
    check("bl", 32'(branch), 32'd1);
    branch_code = 6'd14;
    #1;
    check("bb", 32'(branch), 32'd0);

    idle_in();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
